avmm_cfg_arbiter: RTL and testbench
===================================

Name: avmm_cfg_arbiter

Overview:
- Shares one Avalon-MM configuration master port between NUM_REQ independent requesters.
- Example requesters: the looped config write sequencer and a status/readback poller.
- Accepts one single-beat read or write command per requester via valid/ready, selects a winner round-robin, and drives the Avalon-MM port while honouring waitrequest.
- Returns a per-requester response pulse with read data and a timeout error flag.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 17, Avalon-MM address width
DATA_W, 32, Avalon-MM data width
TIMEOUT_CYC, 1024, max cycles waitrequest may stay high before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accepted (one-hot pulse)
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_be  in  NUM_REQ*DATA_W/8  packed byteenables
rsp_valid  out  NUM_REQ  one-hot response pulse to command owner
rsp_rdata  out  DATA_W  read data, shared, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
busy  out  1  high in ISSUE and RESP
avmm_address  out  ADDR_W  Avalon-MM address
avmm_writedata  out  DATA_W  Avalon-MM write data
avmm_byteenable  out  DATA_W/8  Avalon-MM byteenable
avmm_write  out  1  Avalon-MM write strobe
avmm_read  out  1  Avalon-MM read strobe
avmm_readdata  in  DATA_W  Avalon-MM read data
avmm_waitrequest  in  1  Avalon-MM waitrequest

Behaviour:
Reset:
- All outputs 0; state IDLE; timeout counter 0.
- last_grant = NUM_REQ-1, so requester 0 has first priority.

FSM states: IDLE, ISSUE, RESP.

IDLE:
- Winner = first i with req_valid[i]=1, searching from last_grant+1 modulo NUM_REQ.
- req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits 0.
- On that edge: latch owner, write, addr, wdata, be; clear counter; go ISSUE.
- No valid requests: stay IDLE, req_ready=0.
- Requester may drop req_valid before ready with no effect; arbitration is re-evaluated every IDLE cycle.

ISSUE:
- avmm_address, avmm_writedata and avmm_byteenable driven from registered latched fields.
- avmm_write=latched write; avmm_read=~latched write. Never both high.
- Strobe and fields held stable while avmm_waitrequest=1; counter increments each such cycle.
- avmm_waitrequest=0: transfer completes this cycle. Capture avmm_readdata for a read (0 for a write), err=0, go RESP.
- Counter reaches TIMEOUT_CYC-1 with waitrequest still 1: abort. Capture rdata=0, err=1, go RESP.
- Strobes deassert from the next cycle in both cases.

RESP (one cycle):
- rsp_valid[owner]=1; rsp_rdata and rsp_err from the captured values.
- last_grant <= owner; go IDLE.
- rsp_rdata/rsp_err hold their last value outside RESP; only meaningful with rsp_valid.

Latency:
- Accept at cycle T, strobe at T+1; with waitrequest=0 at T+1, rsp_valid at T+2.
- Back-to-back: next accept at T+3.
- Minimum 3 cycles per transaction; at most one outstanding transaction.

Requester rule:
- Hold addr/wdata/be/write stable while req_valid=1 and req_ready=0.

Fairness:
- All requesters continuously valid: grants rotate 0,1,...,NUM_REQ-1,0.
- A lone requester may be granted repeatedly.

Reset mid-transaction:
- Transaction is aborted; no rsp_valid is issued.
- Strobes are 0 after the reset edge; the requester must reissue.

Widths:
- Counter width clog2(TIMEOUT_CYC).
- Packed slices indexed as above; the winner index is a clog2(NUM_REQ)-bit register.

Test Plan:
- Single write: req0 write addr 0x00010, data 0xDEADBEEF, be 0xF, waitrequest=0 -> req_ready[0] at T, avmm_write=1 with those values at T+1 only, rsp_valid[0] at T+2 with rsp_err=0.
- Read with wait states: req1 read addr 0x1FFFF, waitrequest high for 3 cycles, readdata=0x12345678 when it drops -> avmm_read held for 4 cycles with stable address; rsp_valid[1], rsp_rdata=0x12345678.
- Fairness: both requesters continuously valid for 6 transactions from reset -> grant order 0,1,0,1,0,1; each req_ready is a 1-cycle one-hot pulse.
- Timeout: TIMEOUT_CYC=8, waitrequest stuck high -> avmm_read high exactly 8 cycles then 0; rsp_valid pulse with rsp_err=1, rsp_rdata=0; next request is served normally.
- Reset mid-ISSUE: rst asserted during a waitrequest stall -> next cycle avmm_write/read=0, busy=0, no rsp_valid; after release, requester 0 has priority.
- Withdrawn request: req1 valid for 1 cycle while busy, then dropped -> no grant to req1; req_ready stays 0.

Source files
------------

// File: rtl/avmm_cfg_arbiter_if.sv
// Signal bundle between NUM_REQ config requesters, the arbiter and one Avalon-MM slave.
// Handshake: a command transfers on a rising clk edge where req_valid[i] && req_ready[i]; while valid
// is high and ready low the requester holds write/addr/wdata/be stable; rsp_valid is a one-cycle pulse.
interface avmm_cfg_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_wdata;
  logic [NUM_REQ*DATA_W/8-1:0] req_be;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic                        busy;
  logic [ADDR_W-1:0]           avmm_address;
  logic [DATA_W-1:0]           avmm_writedata;
  logic [DATA_W/8-1:0]         avmm_byteenable;
  logic                        avmm_write;
  logic                        avmm_read;
  logic [DATA_W-1:0]           avmm_readdata;
  logic                        avmm_waitrequest;

  // Arbiter side: it is the Avalon-MM master.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    input  avmm_readdata, avmm_waitrequest,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output avmm_address, avmm_writedata, avmm_byteenable, avmm_write, avmm_read
  );

  // Environment side: requesters plus the Avalon-MM slave.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    output avmm_readdata, avmm_waitrequest,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  avmm_address, avmm_writedata, avmm_byteenable, avmm_write, avmm_read
  );
endinterface

// File: rtl/avmm_cfg_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM config master between NUM_REQ requesters,
// one single-beat command in flight, with a waitrequest timeout that aborts the transfer.
module avmm_cfg_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  avmm_cfg_arbiter_if.master bus,
  output logic [1:0]         dbg_state
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   last_grant, owner, winner;
  logic               found;
  logic               lat_write;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [BE_W-1:0]    lat_be;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  cap_rdata;
  logic               cap_err;
  logic               wait_expired;

  // First valid requester after the previous owner, wrapping modulo NUM_REQ.
  always_comb begin : pick
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign wait_expired = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (found) state_n = ISSUE;
      ISSUE:   if (!bus.avmm_waitrequest || wait_expired) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (state == IDLE && found && !rst) bus.req_ready[winner] = 1'b1;
    if (state == RESP) bus.rsp_valid[owner] = 1'b1;
  end

  assign bus.avmm_write      = (state == ISSUE) && lat_write;
  assign bus.avmm_read       = (state == ISSUE) && !lat_write;
  assign bus.avmm_address    = lat_addr;
  assign bus.avmm_writedata  = lat_wdata;
  assign bus.avmm_byteenable = lat_be;
  assign bus.rsp_rdata       = cap_rdata;
  assign bus.rsp_err         = cap_err;
  assign bus.busy            = (state != IDLE);
  assign dbg_state           = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      cnt        <= '0;
      cap_rdata  <= '0;
      cap_err    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner     <= winner;
            lat_write <= bus.req_write[winner];
            lat_addr  <= bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
            lat_wdata <= bus.req_wdata[int'(winner)*DATA_W +: DATA_W];
            lat_be    <= bus.req_be[int'(winner)*BE_W +: BE_W];
            cnt       <= '0;
          end
        end
        ISSUE: begin
          if (!bus.avmm_waitrequest) begin
            cap_rdata <= lat_write ? '0 : bus.avmm_readdata;
            cap_err   <= 1'b0;
          end else if (wait_expired) begin
            // Slave never answered: report an error with zero data.
            cap_rdata <= '0;
            cap_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    last_grant <= owner;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_avmm_cfg_arbiter.sv
// Self-checking bench for avmm_cfg_arbiter: directed scenario tasks plus a randomized run
// checked against a transaction-level model of the arbitration and latency rules.
module tb_avmm_cfg_arbiter;
  localparam int NR = 3;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  avmm_cfg_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  avmm_cfg_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0;
    bus.avmm_readdata = '0; bus.avmm_waitrequest = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cmd(input int r, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    bus.req_valid[r]            = 1'b1;
    bus.req_write[r]            = wr;
    bus.req_addr[r*AW +: AW]    = a;
    bus.req_wdata[r*DW +: DW]   = d;
    bus.req_be[r*BW +: BW]      = be;
  endtask

  task automatic drop_cmd(input int r);
    bus.req_valid[r] = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if ({bus.avmm_write, bus.avmm_read} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {bus.avmm_write, bus.avmm_read}); end
    n_checks++; if (bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", bus.rsp_rdata, bus.rsp_err); end
    n_checks++; if (bus.avmm_address !== '0 || bus.avmm_writedata !== '0 || bus.avmm_byteenable !== '0) begin n_fail++; $display("FAIL reset_fields: got %h/%h/%h want 0", bus.avmm_address, bus.avmm_writedata, bus.avmm_byteenable); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    bus.avmm_waitrequest = 1'b0;
    set_cmd(0, 1'b1, 17'h00010, 32'hDEADBEEF, 4'hF);
    #1;
    n_checks++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL wr_ready: got %b want 001", bus.req_ready); end
    n_checks++; if (bus.avmm_write !== 1'b0) begin n_fail++; $display("FAIL wr_early_strobe: got %b want 0", bus.avmm_write); end
    @(negedge clk); drop_cmd(0); #1;
    n_checks++; if (bus.avmm_write !== 1'b1 || bus.avmm_read !== 1'b0) begin n_fail++; $display("FAIL wr_strobe: got w%b r%b want w1 r0", bus.avmm_write, bus.avmm_read); end
    n_checks++; if (bus.avmm_address !== 17'h00010 || bus.avmm_writedata !== 32'hDEADBEEF || bus.avmm_byteenable !== 4'hF) begin n_fail++; $display("FAIL wr_fields: got %h/%h/%h want 00010/deadbeef/f", bus.avmm_address, bus.avmm_writedata, bus.avmm_byteenable); end
    n_checks++; if (bus.busy !== 1'b1 || bus.rsp_valid !== '0) begin n_fail++; $display("FAIL wr_issue_busy: got busy %b rsp %b want 1/000", bus.busy, bus.rsp_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 3'b001 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got %b err %b want 001 err 0", bus.rsp_valid, bus.rsp_err); end
    n_checks++; if (bus.avmm_write !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_off: got %b want 0", bus.avmm_write); end
    @(negedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin n_fail++; $display("FAIL wr_done: got busy %b rsp %b want 0/000", bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_read_wait();
    int n_read = 0;
    @(negedge clk);
    bus.avmm_waitrequest = 1'b1;
    set_cmd(1, 1'b0, 17'h1FFFF, 32'h0, 4'hF);
    #1;
    n_checks++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL rd_ready: got %b want 010", bus.req_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drop_cmd(1);
      bus.avmm_waitrequest = (k < 3);
      bus.avmm_readdata    = (k < 3) ? (32'hBAD00000 + k) : 32'h12345678;
      #1;
      if (bus.avmm_read === 1'b1) n_read++;
      n_checks++; if (bus.avmm_address !== 17'h1FFFF || bus.avmm_write !== 1'b0 || bus.rsp_valid !== '0) begin n_fail++; $display("FAIL rd_hold_%0d: got addr %h w %b rsp %b want 1ffff 0 000", k, bus.avmm_address, bus.avmm_write, bus.rsp_valid); end
    end
    n_checks++; if (n_read != 4) begin n_fail++; $display("FAIL rd_strobe_len: got %0d want 4", n_read); end
    @(negedge clk);
    bus.avmm_readdata = 32'hFFFF0000;
    #1;
    n_checks++; if (bus.rsp_valid !== 3'b010 || bus.rsp_rdata !== 32'h12345678 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got %b %h err %b want 010 12345678 err 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    n_checks++; if (bus.avmm_read !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_off: got %b want 0", bus.avmm_read); end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    int last_cyc = 0;
    do_reset();
    bus.avmm_waitrequest = 1'b0;
    for (int c = 0; c < 40 && g < 6; c++) begin
      @(negedge clk);
      set_cmd(0, 1'b1, AW'(c), DW'(c), 4'hF);
      set_cmd(1, 1'b1, AW'(c + 100), DW'(c), 4'h3);
      #1;
      if (bus.req_ready !== '0) begin
        n_checks++; if (bus.req_ready !== (NR'(1) << (g % 2))) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", g, bus.req_ready, NR'(1) << (g % 2)); end
        if (g > 0) begin
          n_checks++; if (c - last_cyc != 3) begin n_fail++; $display("FAIL rr_spacing_%0d: got %0d want 3", g, c - last_cyc); end
        end
        last_cyc = c;
        g++;
      end
    end
    n_checks++; if (g != 6) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 6", g); end
    @(negedge clk); drop_cmd(0); drop_cmd(1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n_read = 0, n_rsp = 0, last_read = -1, rsp_at = -1;
    @(negedge clk);
    bus.avmm_waitrequest = 1'b1;
    bus.avmm_readdata    = 32'hFFFFFFFF;
    set_cmd(0, 1'b0, 17'h00ABC, 32'h0, 4'hF);
    #1;
    n_checks++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL to_ready: got %b want 001", bus.req_ready); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) drop_cmd(0);
      #1;
      if (bus.avmm_read === 1'b1) begin n_read++; last_read = k; end
      if (bus.rsp_valid !== '0) begin
        n_rsp++; rsp_at = k;
        n_checks++; if (bus.rsp_valid !== 3'b001 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== '0) begin n_fail++; $display("FAIL to_rsp: got %b err %b data %h want 001 err 1 data 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      end
    end
    n_checks++; if (n_read != TC) begin n_fail++; $display("FAIL to_strobe_len: got %0d want %0d", n_read, TC); end
    n_checks++; if (n_rsp != 1) begin n_fail++; $display("FAIL to_rsp_count: got %0d want 1", n_rsp); end
    n_checks++; if (rsp_at != last_read + 1) begin n_fail++; $display("FAIL to_rsp_timing: got %0d want %0d", rsp_at, last_read + 1); end
    // Same requester again, slave now responsive.
    @(negedge clk);
    bus.avmm_waitrequest = 1'b0;
    set_cmd(0, 1'b1, 17'h00055, 32'h0BADCAFE, 4'h5);
    #1;
    n_checks++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL to_next_ready: got %b want 001", bus.req_ready); end
    @(negedge clk); drop_cmd(0); #1;
    n_checks++; if (bus.avmm_write !== 1'b1 || bus.avmm_address !== 17'h00055 || bus.avmm_byteenable !== 4'h5) begin n_fail++; $display("FAIL to_next_strobe: got w%b %h %h want w1 00055 5", bus.avmm_write, bus.avmm_address, bus.avmm_byteenable); end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 3'b001 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== '0) begin n_fail++; $display("FAIL to_next_rsp: got %b err %b %h want 001 err 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.avmm_waitrequest = 1'b1;
    set_cmd(1, 1'b1, 17'h0F0F0, 32'h11112222, 4'hF);
    #1;
    n_checks++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL rm_ready: got %b want 010", bus.req_ready); end
    @(negedge clk); drop_cmd(1); #1;
    n_checks++; if (bus.avmm_write !== 1'b1) begin n_fail++; $display("FAIL rm_stall_strobe: got %b want 1", bus.avmm_write); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if ({bus.avmm_write, bus.avmm_read} !== 2'b00 || bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin n_fail++; $display("FAIL rm_after_reset: got strobes %b busy %b rsp %b want 00 0 000", {bus.avmm_write, bus.avmm_read}, bus.busy, bus.rsp_valid); end
    rst = 1'b0;
    bus.avmm_waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp_%0d: got rsp %b busy %b want 000 0", k, bus.rsp_valid, bus.busy); end
    end
    @(negedge clk);
    set_cmd(0, 1'b0, 17'h00001, 32'h0, 4'hF);
    set_cmd(1, 1'b0, 17'h00002, 32'h0, 4'hF);
    #1;
    n_checks++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rm_priority: got %b want 001", bus.req_ready); end
    @(negedge clk); drop_cmd(0); drop_cmd(1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_withdrawn();
    @(negedge clk);
    bus.avmm_waitrequest = 1'b1;
    set_cmd(0, 1'b0, 17'h00100, 32'h0, 4'hF);
    #1;
    n_checks++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL wd_ready0: got %b want 001", bus.req_ready); end
    @(negedge clk); drop_cmd(0); set_cmd(1, 1'b1, 17'h00200, 32'h77777777, 4'hF); #1;
    n_checks++; if (bus.req_ready !== '0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL wd_busy_ready: got %b busy %b want 000 1", bus.req_ready, bus.busy); end
    @(negedge clk); drop_cmd(1); #1;
    n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL wd_dropped_ready: got %b want 000", bus.req_ready); end
    @(negedge clk); bus.avmm_waitrequest = 1'b0; bus.avmm_readdata = 32'hCAFEF00D; #1;
    n_checks++; if (bus.avmm_read !== 1'b1 || bus.avmm_address !== 17'h00100) begin n_fail++; $display("FAIL wd_strobe: got r%b %h want r1 00100", bus.avmm_read, bus.avmm_address); end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 3'b001 || bus.rsp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wd_rsp: got %b %h want 001 cafef00d", bus.rsp_valid, bus.rsp_rdata); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.req_ready !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL wd_no_grant_%0d: got %b busy %b want 000 0", k, bus.req_ready, bus.busy); end
    end
  endtask

  // ---------------- randomized run with reference model ----------------
  logic [DW-1:0] mem [int];

  function automatic logic [DW-1:0] mem_read(input int a);
    if (mem.exists(a)) return mem[a];
    return DW'(a) ^ 32'hA5A50000;
  endfunction

  task automatic test_random();
    bit              has_cmd [NR];
    logic            cw [NR];
    logic [AW-1:0]   ca [NR];
    logic [DW-1:0]   cd [NR];
    logic [BW-1:0]   cb [NR];
    bit              m_inflight = 0, m_rsp = 0, m_err = 0;
    int              m_last = NR - 1, m_owner = 0, m_j = 0, m_stall = 0;
    logic            m_write = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_wdata = '0, m_rdata = '0, cur;
    logic [BW-1:0]   m_be = '0;
    logic [NR-1:0]   exp_ready, exp_rsp;
    logic            exp_wr, exp_rd;
    int              w, grants = 0;
    for (int r = 0; r < NR; r++) has_cmd[r] = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (!has_cmd[r]) drop_cmd(r);
        if (!has_cmd[r] && $urandom_range(0, 2) == 0) begin
          has_cmd[r] = 1; cw[r] = 1'($urandom_range(0, 1)); ca[r] = AW'($urandom_range(0, 15));
          cd[r] = $urandom; cb[r] = BW'($urandom_range(1, 15));
          set_cmd(r, cw[r], ca[r], cd[r], cb[r]);
        end
      end
      exp_ready = '0; exp_rsp = '0; exp_wr = 1'b0; exp_rd = 1'b0;
      bus.avmm_readdata = $urandom;
      if (m_rsp) begin
        exp_rsp[m_owner] = 1'b1;
        bus.avmm_waitrequest = 1'($urandom_range(0, 1));
      end else if (m_inflight) begin
        exp_wr = m_write; exp_rd = !m_write;
        if (m_j < m_stall && m_j == TC - 1) begin
          bus.avmm_waitrequest = 1'b1;
          m_rdata = '0; m_err = 1; m_inflight = 0; m_rsp = 1;
        end else if (m_j < m_stall) begin
          bus.avmm_waitrequest = 1'b1;
          m_j++;
        end else begin
          bus.avmm_waitrequest = 1'b0;
          cur = mem_read(int'(m_addr));
          if (m_write) begin
            for (int b = 0; b < BW; b++) if (m_be[b]) cur[8*b +: 8] = m_wdata[8*b +: 8];
            mem[int'(m_addr)] = cur;
            m_rdata = '0;
          end else begin
            bus.avmm_readdata = cur;
            m_rdata = cur;
          end
          m_err = 0; m_inflight = 0; m_rsp = 1;
        end
      end else begin
        bus.avmm_waitrequest = 1'($urandom_range(0, 1));
        w = -1;
        for (int k = 1; k <= NR; k++) if (w < 0 && has_cmd[(m_last + k) % NR]) w = (m_last + k) % NR;
        if (w >= 0) begin
          exp_ready[w] = 1'b1; grants++;
          m_inflight = 1; m_owner = w; m_write = cw[w]; m_addr = ca[w]; m_wdata = cd[w]; m_be = cb[w];
          m_j = 0; m_stall = ($urandom_range(0, 7) == 0) ? TC + 4 : $urandom_range(0, 3);
          has_cmd[w] = 0;
        end
      end
      #1;
      n_checks++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
      n_checks++; if ({bus.avmm_write, bus.avmm_read} !== {exp_wr, exp_rd}) begin n_fail++; $display("FAIL rnd_strobes c%0d: got %b want %b", c, {bus.avmm_write, bus.avmm_read}, {exp_wr, exp_rd}); end
      if (exp_wr || exp_rd) begin
        n_checks++; if (bus.avmm_address !== m_addr || bus.avmm_byteenable !== m_be || (exp_wr && bus.avmm_writedata !== m_wdata)) begin n_fail++; $display("FAIL rnd_fields c%0d: got %h/%h/%h want %h/%h/%h", c, bus.avmm_address, bus.avmm_byteenable, bus.avmm_writedata, m_addr, m_be, m_wdata); end
      end
      n_checks++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, exp_rsp); end
      if (exp_rsp != '0) begin
        n_checks++; if (bus.rsp_rdata !== m_rdata || bus.rsp_err !== m_err) begin n_fail++; $display("FAIL rnd_rsp_data c%0d: got %h err %b want %h err %b", c, bus.rsp_rdata, bus.rsp_err, m_rdata, m_err); end
        m_last = m_owner; m_rsp = 0;
      end
    end
    n_checks++; if (grants < 20) begin n_fail++; $display("FAIL rnd_progress: got %0d grants want at least 20", grants); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_withdrawn();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
